// File: rtl/x_micro_scope_readout_if.sv
// Scope RAM control port plus the outgoing TX byte stream.
// The controller side uses the master modport.
interface x_micro_scope_readout_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic              o_start;
    logic              i_busy;
    logic              o_ren;
    logic [ADDR_W-1:0] o_raddr;
    logic [DATA_W-1:0] i_data;
    logic              o_tx_valid;
    logic [7:0]        o_tx_data;
    logic              i_tx_ready;

    modport master (
        output o_start,
        output o_ren,
        output o_raddr,
        output o_tx_valid,
        output o_tx_data,
        input  i_busy,
        input  i_data,
        input  i_tx_ready
    );

    modport slave (
        input  o_start,
        input  o_ren,
        input  o_raddr,
        input  o_tx_valid,
        input  o_tx_data,
        output i_busy,
        output i_data,
        output i_tx_ready
    );
endinterface

// File: rtl/x_micro_scope_readout.sv
// Capture-and-dump sequencer: one scope capture, then every RAM word as LSB-first bytes.
// Define X_MICRO_SCOPE_READOUT_HDR_EN to prefix the stream with A5 5A ADDR_W.
module x_micro_scope_readout #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_arm,
    output logic o_busy,
    output logic o_done,
    x_micro_scope_readout_if.master bus
);

    localparam int NB = DATA_W / 8;
    localparam int BC_W = $clog2(NB) + 2;
    localparam logic [BC_W-1:0] LAST_B = BC_W'(NB - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO,
`ifdef X_MICRO_SCOPE_READOUT_HDR_EN
        S_HDR,
`endif
        S_READ,
        S_LATCH,
        S_SEND,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [BC_W-1:0]   bcnt_q, bcnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            raddr_q <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            raddr_q <= raddr_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
        end
    end

    // The read address is only live in READ and is held afterwards.
    assign bus.o_raddr = (state_q == S_READ) ? addr_q : raddr_q;
    assign o_busy      = (state_q != S_IDLE);

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        raddr_d        = raddr_q;
        bcnt_d         = bcnt_q;
        shift_d        = shift_q;
        o_done         = 1'b0;
        bus.o_start    = 1'b0;
        bus.o_ren      = 1'b0;
        bus.o_tx_valid = 1'b0;
        bus.o_tx_data  = 8'h00;

        unique case (state_q)
            S_IDLE: begin
                if (i_arm) state_d = S_START;
            end
            S_START: begin
                bus.o_start = 1'b1;
                state_d     = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (bus.i_busy) state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
`ifdef X_MICRO_SCOPE_READOUT_HDR_EN
                if (!bus.i_busy) state_d = S_HDR;
`else
                if (!bus.i_busy) state_d = S_READ;
`endif
            end
`ifdef X_MICRO_SCOPE_READOUT_HDR_EN
            S_HDR: begin
                bus.o_tx_valid = 1'b1;
                unique case (bcnt_q)
                    BC_W'(0): bus.o_tx_data = 8'hA5;
                    BC_W'(1): bus.o_tx_data = 8'h5A;
                    default:  bus.o_tx_data = 8'(ADDR_W);
                endcase
                if (bus.i_tx_ready) begin
                    if (bcnt_q == BC_W'(2)) begin
                        bcnt_d  = '0;
                        state_d = S_READ;
                    end else begin
                        bcnt_d = bcnt_q + BC_W'(1);
                    end
                end
            end
`endif
            S_READ: begin
                bus.o_ren = 1'b1;
                raddr_d   = addr_q;
                state_d   = S_LATCH;
            end
            S_LATCH: begin
                shift_d = bus.i_data;
                bcnt_d  = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                bus.o_tx_valid = 1'b1;
                bus.o_tx_data  = shift_q[7:0];
                if (bus.i_tx_ready) begin
                    shift_d = shift_q >> 8;
                    if (bcnt_q == LAST_B) begin
                        bcnt_d  = '0;
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = (addr_q == ADDR_MAX) ? S_DONE : S_READ;
                    end else begin
                        bcnt_d = bcnt_q + BC_W'(1);
                    end
                end
            end
            S_DONE: begin
                o_done  = 1'b1;
                addr_d  = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_x_micro_scope_readout.sv
// Bench for x_micro_scope_readout: scope model, byte-stream capture, reference stream.
// Honours X_MICRO_SCOPE_READOUT_HDR_EN when building the expected stream.
module tb_x_micro_scope_readout;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int NB = DATA_W / 8;
    localparam int WORDS = 1 << ADDR_W;
`ifdef X_MICRO_SCOPE_READOUT_HDR_EN
    localparam int HDR_N = 3;
`else
    localparam int HDR_N = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic arm;
    logic ready;
    logic busy;
    logic done;

    always #5 clk = ~clk;

    x_micro_scope_readout_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    x_micro_scope_readout #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk  (clk),
        .i_rst  (rst_n),
        .i_arm  (arm),
        .o_busy (busy),
        .o_done (done),
        .bus    (bus)
    );

    // Scope model: RAM plus a capture-busy window that follows o_start.
    logic [DATA_W-1:0] mem [WORDS];
    logic [DATA_W-1:0] sdata;
    logic sb;
    int sph, scnt;
    int sc_delay = 2;
    int sc_hold = 3;

    assign bus.i_busy     = sb;
    assign bus.i_data     = sdata;
    assign bus.i_tx_ready = ready;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb <= 1'b0; sph <= 0; scnt <= 0;
        end else if (bus.o_start) begin
            sph <= 1; scnt <= sc_delay;
        end else if (sph == 1) begin
            if (scnt <= 1) begin sb <= 1'b1; sph <= 2; scnt <= sc_hold; end
            else scnt <= scnt - 1;
        end else if (sph == 2) begin
            if (scnt <= 1) begin sb <= 1'b0; sph <= 0; end
            else scnt <= scnt - 1;
        end
    end

    always @(posedge clk) begin
        if (bus.o_ren) sdata <= mem[bus.o_raddr];
    end

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int n_start, n_done, n_ren, ren_early, stab_viol, busy_viol;
    int first_start_cyc, first_ren_cyc, last_hs_cyc, done_cyc;
    int vectors = 0;
    int miscompares = 0;

    // Reference stream: optional header, then each word LSB byte first.
    task automatic build_model();
        exp_q.delete();
`ifdef X_MICRO_SCOPE_READOUT_HDR_EN
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'(ADDR_W));
`endif
        for (int k = 0; k < WORDS; k++)
            for (int b = 0; b < NB; b++)
                exp_q.push_back(8'((mem[k] >> (8 * b)) & 'hFF));
    endtask

    function automatic int stream_diff();
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (got_q[i] !== exp_q[i]) return i;
        return (got_q.size() == exp_q.size()) ? -1 : n;
    endfunction

    // Drives arm/ready and records everything seen; entered and left at posedge+1.
    task automatic run_dump(input bit rnd, input bit spam, input int stop_after,
                            input int budget, output bit to);
        bit pv, pr, pdone, fin, sp1, sp2;
        logic [7:0] pdat;
        got_q.delete();
        n_start = 0; n_done = 0; n_ren = 0; ren_early = 0;
        stab_viol = 0; busy_viol = 0;
        first_start_cyc = -1; first_ren_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
        pv = 0; pr = 0; pdone = 0; fin = 0; sp1 = 0; sp2 = 0; pdat = 8'h00;
        for (int c = 0; c < budget && !fin; c++) begin
            arm = (c == 0);
            if (spam && !sp1 && sph == 2 && scnt < 50) begin arm = 1'b1; sp1 = 1; end
            if (spam && !sp2 && got_q.size() == 100) begin arm = 1'b1; sp2 = 1; end
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (bus.o_start) begin
                n_start++;
                if (first_start_cyc < 0) first_start_cyc = c;
            end
            if (bus.o_ren) begin
                n_ren++;
                if (first_ren_cyc < 0) first_ren_cyc = c;
                if (sph != 0 || sb) ren_early++;
            end
            if (pv && !pr && (!bus.o_tx_valid || bus.o_tx_data !== pdat)) stab_viol++;
            if (bus.o_tx_valid && ready) begin
                got_q.push_back(bus.o_tx_data);
                last_hs_cyc = c;
            end
            if (done) begin
                n_done++;
                if (!busy) busy_viol++;
                if (done_cyc < 0) done_cyc = c;
            end else if (pdone) begin
                if (busy) busy_viol++;
                fin = 1;
            end
            pv = bus.o_tx_valid; pr = ready; pdat = bus.o_tx_data; pdone = done;
            if (stop_after > 0 && got_q.size() == stop_after) fin = 1;
            @(posedge clk); #1;
        end
        arm = 1'b0;
        to = !fin;
    endtask

    task automatic test_reset();
        logic [ADDR_W+12:0] outs;
        rst_n = 1'b0; arm = 1'b0; ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        outs = {busy, done, bus.o_start, bus.o_ren, bus.o_raddr, bus.o_tx_valid, bus.o_tx_data};
        vectors++;
        if (outs !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, required 0", outs);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || bus.o_start !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: busy=%b start=%b, required 0 0", busy, bus.o_start);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full_dump();
        bit to;
        int d;
        logic [63:0] gh;
        logic [31:0] gt;
        for (int k = 0; k < WORDS; k++) mem[k] = 32'h1000_0000 + 32'(k);
        build_model();
        run_dump(1'b0, 1'b0, 0, WORDS * (2 + NB) + 400, to);
        vectors++;
        if (to) begin miscompares++; $display("FAIL full_timeout: no done within budget"); end
        vectors++;
        if (first_start_cyc != 1) begin
            miscompares++;
            $display("FAIL start_latency: start at cycle %0d, required 1", first_start_cyc);
        end
        d = stream_diff();
        vectors++;
        if (d >= 0) begin
            miscompares++;
            $display("FAIL full_stream: %0d bytes, first diff at %0d, required %0d bytes",
                     got_q.size(), d, exp_q.size());
        end
        gh = '0;
        for (int i = 0; i < 8; i++)
            if (HDR_N + i < got_q.size()) gh[8*i +: 8] = got_q[HDR_N + i];
        vectors++;
        if (gh !== 64'h1000_0001_1000_0000) begin
            miscompares++;
            $display("FAIL head_bytes: got %h, required 1000000110000000", gh);
        end
        gt = '0;
        for (int i = 0; i < 4; i++)
            if (got_q.size() >= 4) gt[8*i +: 8] = got_q[got_q.size() - 4 + i];
        vectors++;
        if (gt !== 32'h1000_07FF) begin
            miscompares++;
            $display("FAIL tail_bytes: got %h, required 100007ff", gt);
        end
        vectors++;
        if (n_start != 1 || n_done != 1) begin
            miscompares++;
            $display("FAIL full_pulses: start=%0d done=%0d, required 1 1", n_start, n_done);
        end
        vectors++;
        if (done_cyc != last_hs_cyc + 1) begin
            miscompares++;
            $display("FAIL done_latency: done %0d last hs %0d, required hs+1", done_cyc, last_hs_cyc);
        end
        vectors++;
        if (done_cyc - first_ren_cyc != WORDS * (2 + NB)) begin
            miscompares++;
            $display("FAIL dump_time: got %0d cycles, required %0d",
                     done_cyc - first_ren_cyc, WORDS * (2 + NB));
        end
        vectors++;
        if (n_ren != WORDS || busy_viol != 0) begin
            miscompares++;
            $display("FAIL ren_busy: ren=%0d busy_viol=%0d, required %0d 0", n_ren, busy_viol, WORDS);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        int d;
        for (int k = 0; k < WORDS; k++) mem[k] = $urandom;
        build_model();
        run_dump(1'b1, 1'b0, 0, WORDS * (2 + 3 * NB) + 400, to);
        vectors++;
        if (to) begin miscompares++; $display("FAIL bp_timeout: no done within budget"); end
        d = stream_diff();
        vectors++;
        if (d >= 0) begin
            miscompares++;
            $display("FAIL bp_stream: %0d bytes, first diff at %0d, required %0d bytes",
                     got_q.size(), d, exp_q.size());
        end
        vectors++;
        if (stab_viol != 0) begin
            miscompares++;
            $display("FAIL bp_stable: %0d changes while stalled, required 0", stab_viol);
        end
        vectors++;
        if (n_done != 1) begin
            miscompares++;
            $display("FAIL bp_done: %0d pulses, required 1", n_done);
        end
    endtask

    task automatic test_busy_window_and_arm();
        bit to;
        int d;
        for (int k = 0; k < WORDS; k++) mem[k] = $urandom;
        build_model();
        sc_delay = 20; sc_hold = 100;
        run_dump(1'b0, 1'b1, 0, WORDS * (2 + NB) + 600, to);
        sc_delay = 2; sc_hold = 3;
        vectors++;
        if (to) begin miscompares++; $display("FAIL bw_timeout: no done within budget"); end
        vectors++;
        if (ren_early != 0) begin
            miscompares++;
            $display("FAIL bw_early_ren: %0d reads during capture, required 0", ren_early);
        end
        vectors++;
        if (n_start != 1) begin
            miscompares++;
            $display("FAIL bw_start: %0d pulses, required 1", n_start);
        end
        d = stream_diff();
        vectors++;
        if (d >= 0) begin
            miscompares++;
            $display("FAIL bw_stream: %0d bytes, first diff at %0d, required %0d bytes",
                     got_q.size(), d, exp_q.size());
        end
        vectors++;
        if (n_done != 1) begin
            miscompares++;
            $display("FAIL bw_done: %0d pulses, required 1", n_done);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int d;
        logic [ADDR_W+12:0] outs;
        for (int k = 0; k < WORDS; k++) mem[k] = $urandom;
        build_model();
        run_dump(1'b0, 1'b0, HDR_N + 5, 200, to);
        vectors++;
        if (to || bus.o_tx_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_setup: timeout=%0b valid=%b, required 0 1", to, bus.o_tx_valid);
        end
        rst_n = 1'b0;
        #1;
        outs = {busy, done, bus.o_start, bus.o_ren, bus.o_raddr, bus.o_tx_valid, bus.o_tx_data};
        vectors++;
        if (outs !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_async: got %h, required 0", outs);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_dump(1'b0, 1'b0, 0, WORDS * (2 + NB) + 400, to);
        vectors++;
        if (to) begin miscompares++; $display("FAIL restart_timeout: no done within budget"); end
        d = stream_diff();
        vectors++;
        if (d >= 0) begin
            miscompares++;
            $display("FAIL restart_stream: %0d bytes, first diff at %0d, required %0d bytes",
                     got_q.size(), d, exp_q.size());
        end
        vectors++;
        if (n_start != 1 || n_done != 1) begin
            miscompares++;
            $display("FAIL restart_pulses: start=%0d done=%0d, required 1 1", n_start, n_done);
        end
    endtask

    initial begin
        test_reset();
        test_full_dump();
        test_backpressure();
        test_busy_window_and_arm();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/x_micro_scope_readout.md
# x_micro_scope_readout

Capture-and-dump sequencer for the micro scope sample RAM. On an arm command it starts one scope capture, waits for the capture to finish, then reads every RAM word in address order and streams it out as bytes over a valid/ready interface. The byte stream feeds the UART TX path. This controller is the only agent driving the scope's start and read ports.

## Interface
Parameters:
- `ADDR_W`, 11: scope RAM address width; word count is 2^ADDR_W.
- `DATA_W`, 32: scope word width; must be a multiple of 8.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset, asynchronous, active-low.
- `i_arm`  in  1  single-cycle command pulse; starts capture and dump.
- `o_busy`  out  1  high in every state except IDLE.
- `o_done`  out  1  one-cycle pulse after the last byte is accepted.
- `o_start`  out  1  scope start pulse.
- `i_busy`  in  1  scope capture-in-progress flag.
- `o_ren`  out  1  scope read enable.
- `o_raddr`  out  ADDR_W  scope read address.
- `i_data`  in  DATA_W  scope read data; valid the cycle after `o_ren`.
- `o_tx_valid`  out  1  byte valid.
- `o_tx_data`  out  8  byte data.
- `i_tx_ready`  in  1  byte sink ready.

## Operation
- Reset value of every output is 0. The internal address counter, byte counter and shift register also reset to 0. The state resets to IDLE.
- IDLE: `i_arm`=1 moves to START.
- START: `o_start`=1 for exactly one cycle, then go to WAIT_HI.
- WAIT_HI: wait for `i_busy`=1, then go to WAIT_LO. There is no timeout.
- WAIT_LO: wait for `i_busy`=0, then go to HDR if the header feature is compiled in, otherwise to READ.
- READ: `o_ren`=1 for one cycle with `o_raddr`=addr, then go to LATCH.
- LATCH: load `i_data` into the shift register, then go to SEND.
- SEND:
  - Present byte = shift[7:0] with `o_tx_valid`=1.
  - On each handshake (`o_tx_valid` & `i_tx_ready`), shift right by 8 and increment the byte count.
  - After DATA_W/8 handshakes, increment addr.
  - If addr was 2^ADDR_W−1, go to DONE. Otherwise return to READ.
- DONE: `o_done`=1 for one cycle, addr resets to 0, then go to IDLE.
- Byte order: least significant byte first within each word. Words go out in ascending address order from 0.
- Addr arithmetic is ADDR_W bits wide and wraps to 0 naturally after the last word.
- Backpressure: `o_tx_valid` and `o_tx_data` hold stable until the handshake completes.
- `i_arm` is ignored whenever `o_busy`=1. It is not queued.
- `o_ren` is asserted only in READ. `o_raddr` holds its value outside READ.
- Reset asserted mid-operation: all outputs go to 0 immediately, asynchronously. A partially sent word is discarded. After reset is released the block sits in IDLE.

## Timing
- `i_arm` at cycle 0 gives `o_start`=1 at cycle 1.
- READ→LATCH→first byte valid takes 3 cycles per word: READ cycle n, LATCH cycle n+1, SEND from n+2.
- Best case per word, with ready held high: 2 + DATA_W/8 cycles. With defaults that is 6 cycles per word.
- Total dump time is 2^ADDR_W·6 cycles, plus HDR bytes when the header feature is present.
- `o_done` rises the cycle after the final handshake.
- `o_busy` falls in the same cycle `o_done` falls.

## Configuration
- `X_MICRO_SCOPE_READOUT_HDR_EN` defined: the HDR state is present.
  - HDR emits bytes 0xA5, then 0x5A, then ADDR_W, using the same valid/ready rules as SEND.
  - After the third handshake, go to READ.
- Macro undefined: the HDR state is absent and WAIT_LO goes directly to READ. The stream then contains only sample bytes.

## Test plan
- Default parameters, ready held at 1, scope model where word k = 0x1000_0000+k: the stream is exactly 8192 bytes, starting 00 00 00 10 01 00 00 10 and ending FF 07 00 10. `o_done` pulses once.
- Ready toggling with a pseudo-random 50% pattern: byte sequence identical to the first scenario, and `o_tx_data` never changes while valid=1 and ready=0.
- Scope raises `i_busy` 20 cycles after `o_start` and holds it for 100 cycles: no `o_ren` occurs before `i_busy` falls, and exactly one `o_start` pulse is seen.
- `i_arm` pulsed during WAIT_LO and again during SEND: no second `o_start` occurs, and the stream is unchanged.
- Reset asserted after byte 5: all outputs are 0 within the same cycle. A subsequent `i_arm` restarts the dump from address 0.
- With `X_MICRO_SCOPE_READOUT_HDR_EN`: the first three bytes are A5 5A 0B, followed by the 8192 sample bytes.
